lock_water_level: RTL and testbench

//  Chamber water-level model and pump sequencer next to TopLevelLockSystem.

---
 rtl/lock_water_level_if.sv | 27 ++
 rtl/lock_water_level.sv | 189 ++++++++++++++++++
 tb/tb_lock_water_level.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/lock_water_level_if.sv
// rtl/lock_water_level_if.sv - command/status bundle between the lock controller and the water-level model
interface lock_water_level_if #(
    parameter int LEVEL_W = 4
) ();
    logic               inc_water_level;
    logic               dec_water_level;
    logic               outer_gate_open;
    logic               inner_gate_open;
    logic [LEVEL_W-1:0] water_level;
    logic               level_high;
    logic               level_low;
    logic               filling;
    logic               draining;
    logic               done;
    logic               cmd_reject;
    logic               fault;

    modport master (
        output inc_water_level, dec_water_level, outer_gate_open, inner_gate_open,
        input  water_level, level_high, level_low, filling, draining, done, cmd_reject, fault
    );

    modport slave (
        input  inc_water_level, dec_water_level, outer_gate_open, inner_gate_open,
        output water_level, level_high, level_low, filling, draining, done, cmd_reject, fault
    );
endinterface

// File: rtl/lock_water_level.sv
// rtl/lock_water_level.sv - chamber water-level model and pump sequencer
// Optional PAUSE watchdog and FAULT state built only with LOCK_LEVEL_TIMEOUT_EN defined.
module lock_water_level #(
    parameter int LEVEL_W        = 4,
    parameter int LEVEL_MAX      = 15,
    parameter int STEP_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    lock_water_level_if.slave lvl
);
    localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [LEVEL_W-1:0] LMAX      = LEVEL_W'(LEVEL_MAX);
    localparam logic [LEVEL_W-1:0] L_ONE     = LEVEL_W'(1);
    localparam logic [LEVEL_W-1:0] L_ZERO    = '0;
    localparam logic [CNT_W-1:0]   STEP_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0]   C_ONE     = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_DRAIN,
        S_PAUSE
`ifdef LOCK_LEVEL_TIMEOUT_EN
        , S_FAULT
`endif
    } state_t;

    typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DOWN} dir_t;

    state_t             state_q, state_d;
    dir_t               dir_q, dir_d;
    logic [LEVEL_W-1:0] level_q, level_d, level_step;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               rej_q, rej_d;
    logic               inc, dec, any_cmd, both_cmd, gate_open, up;

`ifdef LOCK_LEVEL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);
    logic [WD_W-1:0] wd_q, wd_d;
`endif

    assign inc       = lvl.inc_water_level;
    assign dec       = lvl.dec_water_level;
    assign any_cmd   = inc | dec;
    assign both_cmd  = inc & dec;
    assign gate_open = lvl.outer_gate_open | lvl.inner_gate_open;
    assign up        = (state_q == S_FILL);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            dir_q   <= DIR_NONE;
            level_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            rej_q   <= 1'b0;
`ifdef LOCK_LEVEL_TIMEOUT_EN
            wd_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            rej_q   <= rej_d;
`ifdef LOCK_LEVEL_TIMEOUT_EN
            wd_q    <= wd_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        level_d    = level_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        rej_d      = 1'b0;
        level_step = level_q;
`ifdef LOCK_LEVEL_TIMEOUT_EN
        wd_d       = '0;
`endif
        case (state_q)
            S_IDLE: begin
                if (both_cmd || (any_cmd && gate_open)) begin
                    rej_d = 1'b1;
                end else if (inc) begin
                    if (level_q == LMAX) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_FILL;
                        dir_d   = DIR_UP;
                        cnt_d   = '0;
                    end
                end else if (dec) begin
                    if (level_q == L_ZERO) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_DRAIN;
                        dir_d   = DIR_DOWN;
                        cnt_d   = '0;
                    end
                end
            end

            S_FILL, S_DRAIN: begin
                if (gate_open) begin
                    // Level and step counter freeze; dir_q already names the way back.
                    state_d = S_PAUSE;
                    rej_d   = any_cmd;
                end else if (up ? (dec && !inc) : (inc && !dec)) begin
                    if (up ? (level_q == L_ZERO) : (level_q == LMAX)) begin
                        state_d = S_IDLE;
                        dir_d   = DIR_NONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = up ? S_DRAIN : S_FILL;
                        dir_d   = up ? DIR_DOWN : DIR_UP;
                        cnt_d   = '0;
                    end
                end else begin
                    rej_d = both_cmd;
                    if (cnt_q == STEP_LAST) begin
                        cnt_d = '0;
                        if (up && level_q != LMAX) begin
                            level_step = level_q + L_ONE;
                        end else if (!up && level_q != L_ZERO) begin
                            level_step = level_q - L_ONE;
                        end
                        level_d = level_step;
                        // Reaching the target outranks a simultaneous rejected command.
                        if (level_step == (up ? LMAX : L_ZERO)) begin
                            state_d = S_IDLE;
                            dir_d   = DIR_NONE;
                            done_d  = 1'b1;
                            rej_d   = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + C_ONE;
                    end
                end
            end

            S_PAUSE: begin
                rej_d = any_cmd;
                if (!gate_open) begin
                    state_d = (dir_q == DIR_UP) ? S_FILL : S_DRAIN;
                end else begin
`ifdef LOCK_LEVEL_TIMEOUT_EN
                    wd_d = wd_q + WD_ONE;
                    if (wd_q == WD_LAST) begin
                        state_d = S_FAULT;
                    end
`endif
                end
            end

`ifdef LOCK_LEVEL_TIMEOUT_EN
            S_FAULT: begin
                rej_d = any_cmd;
            end
`endif

            default: begin
                state_d = S_IDLE;
                dir_d   = DIR_NONE;
            end
        endcase
    end

    assign lvl.water_level = level_q;
    assign lvl.level_high  = (level_q == LMAX);
    assign lvl.level_low   = (level_q == L_ZERO);
    assign lvl.filling     = (state_q == S_FILL);
    assign lvl.draining    = (state_q == S_DRAIN);
    assign lvl.done        = done_q;
    assign lvl.cmd_reject  = rej_q;
`ifdef LOCK_LEVEL_TIMEOUT_EN
    assign lvl.fault       = (state_q == S_FAULT);
`else
    assign lvl.fault       = 1'b0;
`endif
endmodule

// File: tb/tb_lock_water_level.sv
// tb/tb_lock_water_level.sv - randomized and directed bench for lock_water_level against a behavioural model
module tb_lock_water_level;
    localparam int LEVEL_W = 4;
    localparam int LMAX    = 15;
    localparam int STEP    = 4;
    localparam int TMO     = 64;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    lock_water_level_if #(.LEVEL_W(LEVEL_W)) lvl_if ();

    lock_water_level #(
        .LEVEL_W(LEVEL_W), .LEVEL_MAX(LMAX), .STEP_CYCLES(STEP), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .lvl   (lvl_if)
    );

    // Behavioural model: level, travel direction (+1/-1/0), progress within the current unit.
    int m_level = 0, m_dir = 0, m_ticks = 0, m_pause_len = 0;
    bit m_moving = 0, m_paused = 0, m_fault = 0, m_done = 0, m_rej = 0;

    function automatic int target(input int d);
        return (d > 0) ? LMAX : 0;
    endfunction

    always @(posedge clk) begin
        bit inc, dec, cmd, gate;
        int want;
        inc  = lvl_if.inc_water_level;
        dec  = lvl_if.dec_water_level;
        cmd  = inc || dec;
        gate = lvl_if.outer_gate_open || lvl_if.inner_gate_open;
        want = (inc && !dec) ? 1 : ((dec && !inc) ? -1 : 0);
        m_done = 0;
        m_rej  = 0;
        if (reset) begin
            m_level = 0; m_dir = 0; m_ticks = 0; m_pause_len = 0;
            m_moving = 0; m_paused = 0; m_fault = 0;
        end else if (m_fault) begin
            m_rej = cmd;
        end else if (m_paused) begin
            m_rej = cmd;
            if (!gate) begin
                m_paused = 0;
                m_moving = 1;
            end else begin
                m_pause_len++;
`ifdef LOCK_LEVEL_TIMEOUT_EN
                if (m_pause_len == TMO) begin
                    m_paused = 0;
                    m_fault  = 1;
                end
`endif
            end
        end else if (m_moving) begin
            if (gate) begin
                m_moving = 0; m_paused = 1; m_pause_len = 0;
                m_rej = cmd;
            end else if (want != 0 && want == -m_dir) begin
                if (m_level == target(want)) begin
                    m_moving = 0; m_dir = 0; m_done = 1;
                end else begin
                    m_dir = want; m_ticks = 0;
                end
            end else begin
                m_rej = inc && dec;
                m_ticks++;
                if (m_ticks == STEP) begin
                    m_ticks = 0;
                    m_level += m_dir;
                    if (m_level == target(m_dir)) begin
                        m_moving = 0; m_dir = 0; m_done = 1; m_rej = 0;
                    end
                end
            end
        end else begin
            if ((inc && dec) || (cmd && gate)) begin
                m_rej = 1;
            end else if (want != 0) begin
                if (m_level == target(want)) m_done = 1;
                else begin
                    m_moving = 1; m_dir = want; m_ticks = 0;
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    always @(negedge clk) begin
        chk("level",    int'(lvl_if.water_level), m_level);
        chk("high",     int'(lvl_if.level_high),  int'(m_level == LMAX));
        chk("low",      int'(lvl_if.level_low),   int'(m_level == 0));
        chk("filling",  int'(lvl_if.filling),     int'(m_moving && m_dir > 0));
        chk("draining", int'(lvl_if.draining),    int'(m_moving && m_dir < 0));
        chk("done",     int'(lvl_if.done),        int'(m_done));
        chk("reject",   int'(lvl_if.cmd_reject),  int'(m_rej));
        chk("fault",    int'(lvl_if.fault),       int'(m_fault));
        chk("done_rej_excl", int'(lvl_if.done && lvl_if.cmd_reject), 0);
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic pulse(input bit i, input bit d);
        lvl_if.inc_water_level = i;
        lvl_if.dec_water_level = d;
        tick(1);
        lvl_if.inc_water_level = 1'b0;
        lvl_if.dec_water_level = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    initial begin
        bit seen;
        lvl_if.inc_water_level = 1'b0;
        lvl_if.dec_water_level = 1'b0;
        lvl_if.outer_gate_open = 1'b0;
        lvl_if.inner_gate_open = 1'b0;

        // Reset and quiet idle
        tick(2);
        chk("t1_level", int'(lvl_if.water_level), 0);
        chk("t1_low",   int'(lvl_if.level_low), 1);
        reset = 1'b0;
        tick(10);
        chk("t1_idle_level", int'(lvl_if.water_level), 0);

        // Full fill: 15 units x 4 clocks
        pulse(1, 0);
        chk("t2_filling", int'(lvl_if.filling), 1);
        tick(4);
        chk("t2_level1", int'(lvl_if.water_level), 1);
        tick(56);
        chk("t2_level15", int'(lvl_if.water_level), 15);
        chk("t2_done", int'(lvl_if.done), 1);
        tick(1);
        chk("t2_idle", int'(lvl_if.filling), 0);

        // Commands at the top
        pulse(1, 0);
        chk("t5_done_at_top", int'(lvl_if.done), 1);
        lvl_if.inner_gate_open = 1'b1;
        pulse(0, 1);
        lvl_if.inner_gate_open = 1'b0;
        chk("t5_reject", int'(lvl_if.cmd_reject), 1);
        chk("t5_level", int'(lvl_if.water_level), 15);

        // Fill to 5, reverse, drain to 0
        do_reset();
        chk("t4_reset_level", int'(lvl_if.water_level), 0);
        pulse(1, 0);
        tick(20);
        chk("t4_level5", int'(lvl_if.water_level), 5);
        pulse(0, 1);
        chk("t4_draining", int'(lvl_if.draining), 1);
        tick(4);
        chk("t4_level4", int'(lvl_if.water_level), 4);
        tick(16);
        chk("t4_level0", int'(lvl_if.water_level), 0);
        chk("t4_done", int'(lvl_if.done), 1);
        pulse(1, 1);
        chk("t4_both_reject", int'(lvl_if.cmd_reject), 1);

        // Pause mid-fill at level 6, then resume
        pulse(1, 0);
        tick(24);
        chk("t3_level6", int'(lvl_if.water_level), 6);
        lvl_if.outer_gate_open = 1'b1;
        tick(20);
        chk("t3_paused_level", int'(lvl_if.water_level), 6);
        chk("t3_paused_filling", int'(lvl_if.filling), 0);
        lvl_if.outer_gate_open = 1'b0;
        tick(1);
        chk("t3_resume", int'(lvl_if.filling), 1);
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            tick(1);
            seen = lvl_if.done;
        end
        chk("t3_done_seen", int'(seen), 1);
        chk("t3_level15", int'(lvl_if.water_level), 15);

`ifdef LOCK_LEVEL_TIMEOUT_EN
        do_reset();
        pulse(1, 0);
        lvl_if.inner_gate_open = 1'b1;
        tick(1);
        tick(TMO);
        chk("t6_fault", int'(lvl_if.fault), 1);
        lvl_if.inner_gate_open = 1'b0;
        pulse(1, 0);
        chk("t6_reject", int'(lvl_if.cmd_reject), 1);
        do_reset();
        chk("t6_fault_clear", int'(lvl_if.fault), 0);
        chk("t6_level0", int'(lvl_if.water_level), 0);
`endif

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            lvl_if.inc_water_level = ($urandom_range(0, 11) == 0);
            lvl_if.dec_water_level = ($urandom_range(0, 13) == 0);
            if ($urandom_range(0, 39) == 0) lvl_if.outer_gate_open = ~lvl_if.outer_gate_open;
            if ($urandom_range(0, 59) == 0) lvl_if.inner_gate_open = ~lvl_if.inner_gate_open;
            reset = ($urandom_range(0, 399) == 0);
            tick(1);
        end
        reset = 1'b0;
        lvl_if.inc_water_level = 1'b0;
        lvl_if.dec_water_level = 1'b0;
        tick(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
